video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the arcade FPGA recreations.
- Replaces the hard-wired counter chains used for the horizontal and vertical timers: pixel clock-enable divider, H/V counters, sync, blank, composite sync, and a VBLANK interrupt latch with acknowledge.
- Drives the tile/bullet render pipelines, the CPU interrupt line and the video output stage.
- Geometry is set by parameters, so one block serves several board timings.

---
 rtl/video_timing_gen.sv | 205 ++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator for the arcade board recreations.
//
// A clock-enable divider produces one pixel step every CLK_DIV master
// clocks. The horizontal and vertical counters move only on those steps,
// and all decoded timing (blanking, syncs, line/frame markers) is
// registered from the *next* counter values. Every registered output
// therefore lines up with the hcnt/vcnt shown in the same cycle.
//
// The interrupt latch sets at the start of line VINT_LINE and clears
// on int_ack. A set and an ack in the same clock resolve to "set", so
// an interrupt can never be lost.
//
// Every output flop has an asynchronous reset, so all outputs fall back
// to their idle values as soon as rst rises, even in the middle of a frame.
module video_timing_gen #(
    parameter int CLK_DIV      = 4,
    parameter int HW           = 9,
    parameter int VW           = 9,
    parameter int H_TOTAL      = 384,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 288,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 264,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_LEN   = 8,
    parameter int VINT_LINE    = 224,
    parameter int SYNC_NEG     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          int_ack,
    output logic          pix_ce,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hblank,
    output logic          vblank,
    output logic          n_hsync,
    output logic          n_vsync,
    output logic          n_csync,
    output logic          line_start,
    output logic          frame_start,
    output logic          n_irq
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_INT    = VW'(VINT_LINE);
    localparam logic          SYNC_INV = (SYNC_NEG != 0);

    // ------------------------------------------------------------------
    // Configuration checks. A bad geometry stops elaboration instead of
    // quietly producing a broken raster.
    // ------------------------------------------------------------------
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("video_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_TOTAL < 2 || longint'(H_TOTAL) > (longint'(1) << HW)) begin : g_bad_h_total
        $error("video_timing_gen: HW cannot hold H_TOTAL-1");
    end
    if (V_TOTAL < 2 || longint'(V_TOTAL) > (longint'(1) << VW)) begin : g_bad_v_total
        $error("video_timing_gen: VW cannot hold V_TOTAL-1");
    end
    if (H_ACTIVE < 1 || H_ACTIVE > H_TOTAL) begin : g_bad_h_active
        $error("video_timing_gen: H_ACTIVE out of range");
    end
    if (V_ACTIVE < 1 || V_ACTIVE > V_TOTAL) begin : g_bad_v_active
        $error("video_timing_gen: V_ACTIVE out of range");
    end
    if (H_SYNC_START < 0 || H_SYNC_LEN < 1 || H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_bad_h_sync
        $error("video_timing_gen: horizontal sync window must lie inside the line");
    end
    if (V_SYNC_START < 0 || V_SYNC_LEN < 1 || V_SYNC_START + V_SYNC_LEN > V_TOTAL) begin : g_bad_v_sync
        $error("video_timing_gen: vertical sync window must lie inside the frame");
    end
    if (VINT_LINE < 0 || VINT_LINE >= V_TOTAL) begin : g_bad_vint
        $error("video_timing_gen: VINT_LINE must be a reachable line");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q,         div_d;
    logic          pix_ce_q,      pix_ce_d;
    logic [HW-1:0] hcnt_q,        hcnt_d;
    logic [VW-1:0] vcnt_q,        vcnt_d;
    logic          hblank_q,      hblank_d;
    logic          vblank_q,      vblank_d;
    logic          hsync_q,       hsync_d;
    logic          vsync_q,       vsync_d;
    logic          csync_q,       csync_d;
    logic          line_start_q,  line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          irq_q,         irq_d;

    logic          step;       // divider wraps this clock: a pixel step
    logic          irq_set;    // this step starts the interrupt line
    logic [31:0]   h_next;     // next hcnt widened for window compares
    logic [31:0]   v_next;     // next vcnt widened for window compares

    // Divider: counts 0..CLK_DIV-1; the wrap marks a pixel step
    always_comb begin
        step  = (div_q == DIV_LAST);
        div_d = div_q + 1'b1;
        if (step) begin
            div_d = '0;
        end
        pix_ce_d = step;
    end

    // Raster counters: hcnt wraps at H_TOTAL-1 and carries into vcnt
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (step) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = '0;
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // Timing decode from the next counter values so outputs align with hcnt/vcnt
    always_comb begin
        h_next        = 32'(hcnt_d);
        v_next        = 32'(vcnt_d);
        hblank_d      = (h_next >= H_ACTIVE);
        vblank_d      = (v_next >= V_ACTIVE);
        hsync_d       = (h_next >= H_SYNC_START) && (h_next < H_SYNC_START + H_SYNC_LEN);
        vsync_d       = (v_next >= V_SYNC_START) && (v_next < V_SYNC_START + V_SYNC_LEN);
        csync_d       = hsync_d | vsync_d;
        line_start_d  = step && (hcnt_d == '0);
        frame_start_d = line_start_d && (vcnt_d == '0);
    end

    // Interrupt latch: set beats acknowledge when both land on the same clock
    always_comb begin
        irq_set = line_start_d && (vcnt_d == V_INT);
        irq_d   = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (int_ack) begin
            irq_d = 1'b0;
        end
    end

    // State registers, all cleared asynchronously to their idle values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            pix_ce_q      <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            csync_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_ce_q      <= pix_ce_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            csync_q       <= csync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            irq_q         <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Syncs are held active-high internally and only the pins
    // take the board polarity; the IRQ pin is always active-low.
    // ------------------------------------------------------------------
    assign pix_ce      = pix_ce_q;
    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign n_hsync     = hsync_q ^ SYNC_INV;
    assign n_vsync     = vsync_q ^ SYNC_INV;
    assign n_csync     = csync_q ^ SYNC_INV;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign n_irq       = ~irq_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Three instances cover three geometries:
//   dut0: default board timing (divider, line timing, mid-run reset)
//   dut1: CLK_DIV=1, 16x8 raster, active-high syncs
//   dut2: CLK_DIV=2, 24x12 raster, active-low syncs (frame, vsync, irq, reset mid-sync)
// Expected pixel-step vectors come from a closed-form model (step index k ->
// h = k mod H_TOTAL, v = (k / H_TOTAL) mod V_TOTAL) and are queued before
// release. A per-instance monitor pops one entry on every pix_ce.
module tb_video_timing_gen;

  typedef logic [63:0] vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic ack_a = 1'b0, ack_b = 1'b0, ack_c = 1'b0;

  // ---------------- DUT instances ----------------
  logic       pce_a, hb_a, vb_a, nhs_a, nvs_a, ncs_a, ls_a, fs_a, nirq_a;
  logic [8:0] hcnt_a, vcnt_a;
  logic       pce_b, hb_b, vb_b, nhs_b, nvs_b, ncs_b, ls_b, fs_b, nirq_b;
  logic [3:0] hcnt_b;
  logic [2:0] vcnt_b;
  logic       pce_c, hb_c, vb_c, nhs_c, nvs_c, ncs_c, ls_c, fs_c, nirq_c;
  logic [4:0] hcnt_c;
  logic [3:0] vcnt_c;

  video_timing_gen u_dut_a (
    .clk(clk), .rst(rst_a), .int_ack(ack_a), .pix_ce(pce_a), .hcnt(hcnt_a), .vcnt(vcnt_a),
    .hblank(hb_a), .vblank(vb_a), .n_hsync(nhs_a), .n_vsync(nvs_a), .n_csync(ncs_a),
    .line_start(ls_a), .frame_start(fs_a), .n_irq(nirq_a)
  );

  video_timing_gen #(
    .CLK_DIV(1), .HW(4), .VW(3), .H_TOTAL(16), .H_ACTIVE(10), .H_SYNC_START(12),
    .H_SYNC_LEN(2), .V_TOTAL(8), .V_ACTIVE(6), .V_SYNC_START(6), .V_SYNC_LEN(1),
    .VINT_LINE(6), .SYNC_NEG(0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .int_ack(ack_b), .pix_ce(pce_b), .hcnt(hcnt_b), .vcnt(vcnt_b),
    .hblank(hb_b), .vblank(vb_b), .n_hsync(nhs_b), .n_vsync(nvs_b), .n_csync(ncs_b),
    .line_start(ls_b), .frame_start(fs_b), .n_irq(nirq_b)
  );

  video_timing_gen #(
    .CLK_DIV(2), .HW(5), .VW(4), .H_TOTAL(24), .H_ACTIVE(16), .H_SYNC_START(18),
    .H_SYNC_LEN(3), .V_TOTAL(12), .V_ACTIVE(8), .V_SYNC_START(9), .V_SYNC_LEN(2),
    .VINT_LINE(8), .SYNC_NEG(1)
  ) u_dut_c (
    .clk(clk), .rst(rst_c), .int_ack(ack_c), .pix_ce(pce_c), .hcnt(hcnt_c), .vcnt(vcnt_c),
    .hblank(hb_c), .vblank(vb_c), .n_hsync(nhs_c), .n_vsync(nvs_c), .n_csync(ncs_c),
    .line_start(ls_c), .frame_start(fs_c), .n_irq(nirq_c)
  );

  vec_t act_a, act_b, act_c;
  assign act_a = {16'(hcnt_a), 16'(vcnt_a), 25'd0, hb_a, vb_a, nhs_a, nvs_a, ncs_a, ls_a, fs_a};
  assign act_b = {16'(hcnt_b), 16'(vcnt_b), 25'd0, hb_b, vb_b, nhs_b, nvs_b, ncs_b, ls_b, fs_b};
  assign act_c = {16'(hcnt_c), 16'(vcnt_c), 25'd0, hb_c, vb_c, nhs_c, nvs_c, ncs_c, ls_c, fs_c};

  // ---------------- scoreboard state ----------------
  vec_t exp_q_a[$];
  vec_t exp_q_b[$];
  vec_t exp_q_c[$];
  int   tests    = 0;
  int   failures = 0;
  int   cyc[3];
  bit   mon_en[3];
  vec_t last_exp[3];

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int div_of(input int id);
    case (id)
      0:       return 4;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  // Expected pin vector after pixel step k (k = 0 is the reset state).
  function automatic vec_t model(input int id, input int k);
    int ht, ha, hss, hsl, vt, va, vss, vsl, h, v;
    bit neg, hb, vb, hs, vs, ls, fs;
    case (id)
      0: begin ht = 384; ha = 256; hss = 288; hsl = 32; vt = 264; va = 224; vss = 240; vsl = 8; neg = 1'b1; end
      1: begin ht = 16;  ha = 10;  hss = 12;  hsl = 2;  vt = 8;   va = 6;   vss = 6;   vsl = 1; neg = 1'b0; end
      default: begin ht = 24; ha = 16; hss = 18; hsl = 3; vt = 12; va = 8; vss = 9; vsl = 2; neg = 1'b1; end
    endcase
    h  = k % ht;
    v  = (k / ht) % vt;
    hb = (h >= ha);
    vb = (v >= va);
    hs = (h >= hss) && (h < hss + hsl);
    vs = (v >= vss) && (v < vss + vsl);
    ls = (k > 0) && (h == 0);
    fs = ls && (v == 0);
    return {16'(h), 16'(v), 25'd0, hb, vb, hs ^ neg, vs ^ neg, (hs | vs) ^ neg, ls, fs};
  endfunction

  // ---------------- queue helpers ----------------
  function automatic int q_size(input int id);
    case (id)
      0:       return exp_q_a.size();
      1:       return exp_q_b.size();
      default: return exp_q_c.size();
    endcase
  endfunction

  function automatic vec_t q_pop(input int id);
    case (id)
      0:       return exp_q_a.pop_front();
      1:       return exp_q_b.pop_front();
      default: return exp_q_c.pop_front();
    endcase
  endfunction

  task automatic push_steps(input int id, input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      case (id)
        0:       exp_q_a.push_back(model(id, k));
        1:       exp_q_b.push_back(model(id, k));
        default: exp_q_c.push_back(model(id, k));
      endcase
    end
  endtask

  // ---------------- monitor ----------------
  // Runs 1 time unit after each rising edge. pix_ce must follow the
  // divider cadence; on a step the next queued vector is compared, and
  // between steps the pins must hold the last step with no markers.
  task automatic monitor_cycle(input int id, input logic r, input logic pce, input vec_t act);
    vec_t e;
    if (r) begin
      cyc[id]      = 0;
      last_exp[id] = model(id, 0);
      return;
    end
    if (!mon_en[id]) return;
    cyc[id]++;
    check_bit($sformatf("dut%0d pix_ce cyc%0d", id, cyc[id]), pce, (cyc[id] % div_of(id)) == 0);
    if (pce) begin
      if (q_size(id) == 0) begin
        tests++;
        failures++;
        $display("FAIL dut%0d unexpected step: got %h, want no step (t=%0t)", id, act, $time);
      end else begin
        e = q_pop(id);
        check_vec($sformatf("dut%0d step", id), act, e);
        last_exp[id] = e;
      end
    end else begin
      check_vec($sformatf("dut%0d hold", id), act, {last_exp[id][63:2], 2'b00});
    end
  endtask

  always @(posedge clk) begin #1; monitor_cycle(0, rst_a, pce_a, act_a); end
  always @(posedge clk) begin #1; monitor_cycle(1, rst_b, pce_b, act_b); end
  always @(posedge clk) begin #1; monitor_cycle(2, rst_c, pce_c, act_c); end

  // ---------------- driver tasks ----------------
  function automatic vec_t act_of(input int id);
    case (id)
      0:       return act_a;
      1:       return act_b;
      default: return act_c;
    endcase
  endfunction

  function automatic logic pce_of(input int id);
    case (id)
      0:       return pce_a;
      1:       return pce_b;
      default: return pce_c;
    endcase
  endfunction

  function automatic logic nirq_of(input int id);
    case (id)
      0:       return nirq_a;
      1:       return nirq_b;
      default: return nirq_c;
    endcase
  endfunction

  task automatic check_reset(input int id, input string tag);
    check_vec($sformatf("dut%0d %s outputs", id, tag), act_of(id), model(id, 0));
    check_bit($sformatf("dut%0d %s pix_ce", id, tag), pce_of(id), 1'b0);
    check_bit($sformatf("dut%0d %s n_irq", id, tag), nirq_of(id), 1'b1);
  endtask

  task automatic wait_drain(input int id, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #2;
      if (q_size(id) == 0) done = 1'b1;
    end
    mon_en[id] = 1'b0;
    check_int($sformatf("dut%0d steps left in queue", id), q_size(id), 0);
  endtask

  task automatic wait_cyc(input int id, input int n);
    for (int i = 0; i < 20000 && cyc[id] < n; i++) begin
      @(posedge clk);
      #2;
    end
    if (cyc[id] != n) begin
      tests++;
      failures++;
      $display("FAIL dut%0d wait: got cycle %0d, want %0d", id, cyc[id], n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset(0, "power-up");
    check_reset(1, "power-up");
    check_reset(2, "power-up");

    // Default timing: two full lines, then reset mid-run and restart.
    mon_en[0] = 1'b1;
    push_steps(0, 1, 2 * 384 + 1);
    rst_a = 1'b0;
    wait_drain(0, 4000);
    check_bit("dut0 n_irq idle", nirq_a, 1'b1);
    @(posedge clk);
    #3;
    rst_a = 1'b1;
    #1;
    check_reset(0, "async reset");
    @(posedge clk);
    #2;
    check_reset(0, "held reset");
    mon_en[0] = 1'b1;
    push_steps(0, 1, 20);
    rst_a = 1'b0;
    wait_drain(0, 200);

    // Small raster at CLK_DIV=1: two full 128-clock frames.
    mon_en[1] = 1'b1;
    push_steps(1, 1, 256);
    rst_b = 1'b0;
    wait_drain(1, 400);

    // 24x12 raster at CLK_DIV=2: frames, vsync and the interrupt latch.
    mon_en[2] = 1'b1;
    push_steps(2, 1, 1085);
    rst_c = 1'b0;
    wait_cyc(2, 383);  check_bit("irq before first set", nirq_c, 1'b1);
    wait_cyc(2, 384);  check_bit("irq first set", nirq_c, 1'b0);
    wait_cyc(2, 390);  check_bit("irq held without ack", nirq_c, 1'b0);
    ack_c = 1'b1;
    wait_cyc(2, 391);  check_bit("irq cleared by ack pulse", nirq_c, 1'b1);
    ack_c = 1'b0;
    wait_cyc(2, 950);
    ack_c = 1'b1;
    wait_cyc(2, 959);  check_bit("irq idle with ack held", nirq_c, 1'b1);
    wait_cyc(2, 960);  check_bit("irq set beats held ack", nirq_c, 1'b0);
    wait_cyc(2, 961);  check_bit("irq clears after set", nirq_c, 1'b1);
    ack_c = 1'b0;
    wait_cyc(2, 1535); check_bit("irq before third set", nirq_c, 1'b1);
    wait_cyc(2, 1536); check_bit("irq third set", nirq_c, 1'b0);
    wait_cyc(2, 2111); check_bit("irq kept without ack", nirq_c, 1'b0);
    wait_cyc(2, 2112); check_bit("irq kept at next set", nirq_c, 1'b0);
    wait_cyc(2, 2113); check_bit("irq kept after next set", nirq_c, 1'b0);
    wait_cyc(2, 2170);
    check_bit("vsync active before reset", nvs_c, 1'b0);
    check_bit("irq active before reset", nirq_c, 1'b0);
    check_int("dut2 steps left before reset", q_size(2), 0);
    mon_en[2] = 1'b0;
    #1;
    rst_c = 1'b1;
    #1;
    check_bit("vsync released by reset", nvs_c, 1'b1);
    check_bit("irq released by reset", nirq_c, 1'b1);
    check_reset(2, "mid-sync reset");
    @(posedge clk);
    #2;
    mon_en[2] = 1'b1;
    push_steps(2, 1, 30);
    rst_c = 1'b0;
    wait_drain(2, 200);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Guard against a run that never completes.
  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
